// File: rtl/sdr_proto_pkg.sv
// Shared reply protocol definitions: reply codes, reply type, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sdr_proto_pkg;

    localparam logic [7:0]  REPLY_IDLE  = 8'h02;
    localparam logic [7:0]  REPLY_RUN   = 8'h03;
    localparam logic [7:0]  REPLY_ERASE = 8'h04;
    localparam logic [7:0]  REPLY_MORE  = 8'h05;

    localparam logic [15:0] UDP_PORT    = 16'd1024;

    typedef enum logic [1:0] {
        RT_NONE  = 2'd0,
        RT_DISC  = 2'd1,
        RT_ERASE = 2'd2,
        RT_MORE  = 2'd3
    } reply_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SEND    = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

endpackage

// File: rtl/sdr_reply_send_if.sv
// Reply-sender bus: requester handshakes plus the UDP transmit path.
// Latency: n/a (wiring only).
// Backpressure: udp_tx_enable gates byte consumption.
interface sdr_reply_send_if;
    logic        discovery_reply;
    logic        erase_done;
    logic        send_more;
    logic        run;
    logic [47:0] local_mac;
    logic [31:0] sequence_number;
    logic        udp_tx_enable;
    logic        discovery_ACK;
    logic        erase_ACK;
    logic        send_more_ACK;
    logic        udp_tx_request;
    logic [15:0] udp_tx_length;
    logic [7:0]  udp_tx_data;
    logic        udp_tx_active;
    logic        sending_sync;

    // Reply sender side
    modport master (
        input  discovery_reply, erase_done, send_more, run, local_mac,
               sequence_number, udp_tx_enable,
        output discovery_ACK, erase_ACK, send_more_ACK, udp_tx_request,
               udp_tx_length, udp_tx_data, udp_tx_active, sending_sync
    );

    // Requesters and UDP transmit path side
    modport slave (
        output discovery_reply, erase_done, send_more, run, local_mac,
               sequence_number, udp_tx_enable,
        input  discovery_ACK, erase_ACK, send_more_ACK, udp_tx_request,
               udp_tx_length, udp_tx_data, udp_tx_active, sending_sync
    );
endinterface

// File: rtl/sdr_reply_mux.sv
// Byte-index to payload-byte mux over the latched reply fields.
// Latency: combinational.
// Backpressure: none; caller decides when the index advances.
import sdr_proto_pkg::*;
module sdr_reply_mux #(
    parameter logic [7:0] BOARD_ID         = 8'h06,
    parameter logic [7:0] PROTOCOL_VERSION = 8'd39,
    parameter logic [7:0] CODE_VERSION     = 8'd10,
    parameter int         PAYLOAD_LEN      = 60
) (
    input  logic [15:0] i_idx,
    input  reply_t      i_type,
    input  logic [31:0] i_cnt,
    input  logic        i_run,
    input  logic [47:0] i_mac,
    input  logic [31:0] i_seq,
    input  logic [15:0] i_csum,
    output logic [7:0]  o_byte
);
    logic w_disc;
    logic w_more;

    assign w_disc = (i_type == RT_DISC);
    assign w_more = (i_type == RT_MORE);

    // Select the payload byte; fields not owned by the reply type read as zero
    always_comb begin
        o_byte = 8'h00;
        case (i_idx)
            16'd0:  o_byte = i_cnt[31:24];
            16'd1:  o_byte = i_cnt[23:16];
            16'd2:  o_byte = i_cnt[15:8];
            16'd3:  o_byte = i_cnt[7:0];
            16'd4: begin
                case (i_type)
                    RT_DISC:  o_byte = i_run ? REPLY_RUN : REPLY_IDLE;
                    RT_ERASE: o_byte = REPLY_ERASE;
                    RT_MORE:  o_byte = REPLY_MORE;
                    default:  o_byte = 8'h00;
                endcase
            end
            16'd5:  o_byte = w_disc ? i_mac[47:40] : (w_more ? i_seq[31:24] : 8'h00);
            16'd6:  o_byte = w_disc ? i_mac[39:32] : (w_more ? i_seq[23:16] : 8'h00);
            16'd7:  o_byte = w_disc ? i_mac[31:24] : (w_more ? i_seq[15:8]  : 8'h00);
            16'd8:  o_byte = w_disc ? i_mac[23:16] : (w_more ? i_seq[7:0]   : 8'h00);
            16'd9:  o_byte = w_disc ? i_mac[15:8]  : 8'h00;
            16'd10: o_byte = w_disc ? i_mac[7:0]   : 8'h00;
            16'd11: o_byte = w_disc ? BOARD_ID         : 8'h00;
            16'd12: o_byte = w_disc ? PROTOCOL_VERSION : 8'h00;
            16'd13: o_byte = w_disc ? CODE_VERSION     : 8'h00;
            default: o_byte = 8'h00;
        endcase
        // Trailing checksum slots; i_csum is zero when the checksum is not built
        if (i_idx == 16'(PAYLOAD_LEN - 2)) o_byte = i_csum[15:8];
        if (i_idx == 16'(PAYLOAD_LEN - 1)) o_byte = i_csum[7:0];
    end
endmodule

// File: rtl/sdr_reply_send.sv
// Arbitrates reply requests and streams fixed-length UDP reply payloads.
// Latency: first byte one clock after udp_tx_enable is seen; then one byte per clock.
// Backpressure: udp_tx_enable low holds the current byte/index; optional SDR_REPLY_CHECKSUM_EN.
import sdr_proto_pkg::*;
module sdr_reply_send #(
    parameter logic [7:0] BOARD_ID         = 8'h06,
    parameter logic [7:0] PROTOCOL_VERSION = 8'd39,
    parameter logic [7:0] CODE_VERSION     = 8'd10,
    parameter int         PAYLOAD_LEN      = 60,
    parameter int         REQ_TIMEOUT      = 1024,
    parameter int         GAP_CYCLES       = 12
) (
    input  logic             tx_clock,
    input  logic             reset_n,
    sdr_reply_send_if.master bus
);
    state_t      r_state;
    reply_t      r_type;
    reply_t      w_pick;
    logic [31:0] r_cnt;
    logic [31:0] r_seq;
    logic [47:0] r_mac;
    logic        r_run;
    logic [15:0] r_idx;
    logic [7:0]  r_data;
    logic [31:0] r_tmo;
    logic [15:0] r_gap;
    logic        r_req;
    logic        r_sync;
    logic        r_disc_ack;
    logic        r_erase_ack;
    logic        r_more_ack;
    logic        w_send_ok;
    logic [15:0] w_mux_idx;
    logic [7:0]  w_mux_byte;
    logic [15:0] w_csum;

    // Fixed priority: erase completion, then send-more, then discovery
    always_comb begin
        w_pick = RT_NONE;
        if (bus.erase_done)           w_pick = RT_ERASE;
        else if (bus.send_more)       w_pick = RT_MORE;
        else if (bus.discovery_reply) w_pick = RT_DISC;
    end

    // A byte is consumed on every clock of SEND where the path grants
    assign w_send_ok = (r_state == ST_SEND) && bus.udp_tx_enable;
    // Mux looks one byte ahead so the output register holds the presented byte
    assign w_mux_idx = (r_state == ST_SEND) ? r_idx + 16'd1 : 16'd0;

`ifdef SDR_REPLY_CHECKSUM_EN
    logic [15:0] r_sum;

    // Fold in the byte being consumed so the high checksum byte is complete when muxed
    assign w_csum = (r_idx <= 16'(PAYLOAD_LEN - 3)) ? r_sum + {8'h00, r_data} : r_sum;

    // Running sum of bytes 0..PAYLOAD_LEN-3, one clock behind the output mux
    always_ff @(posedge tx_clock or negedge reset_n) begin
        if (!reset_n)
            r_sum <= 16'h0000;
        else if (r_state == ST_REQUEST)
            r_sum <= 16'h0000;
        else if (w_send_ok && (r_idx <= 16'(PAYLOAD_LEN - 3)))
            r_sum <= w_csum;
    end
`else
    assign w_csum = 16'h0000;
`endif

    sdr_reply_mux #(
        .BOARD_ID         (BOARD_ID),
        .PROTOCOL_VERSION (PROTOCOL_VERSION),
        .CODE_VERSION     (CODE_VERSION),
        .PAYLOAD_LEN      (PAYLOAD_LEN)
    ) u_mux (
        .i_idx  (w_mux_idx),
        .i_type (r_type),
        .i_cnt  (r_cnt),
        .i_run  (r_run),
        .i_mac  (r_mac),
        .i_seq  (r_seq),
        .i_csum (w_csum),
        .o_byte (w_mux_byte)
    );

    // Reply FSM: latch and ack a request, wait for grant, stream, then enforce the idle gap
    always_ff @(posedge tx_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_type      <= RT_NONE;
            r_cnt       <= 32'h0;
            r_seq       <= 32'h0;
            r_mac       <= 48'h0;
            r_run       <= 1'b0;
            r_idx       <= 16'h0;
            r_data      <= 8'h00;
            r_tmo       <= 32'h0;
            r_gap       <= 16'h0;
            r_req       <= 1'b0;
            r_sync      <= 1'b0;
            r_disc_ack  <= 1'b0;
            r_erase_ack <= 1'b0;
            r_more_ack  <= 1'b0;
        end else begin
            r_disc_ack  <= 1'b0;
            r_erase_ack <= 1'b0;
            r_more_ack  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick != RT_NONE) begin
                        r_type      <= w_pick;
                        r_seq       <= bus.sequence_number;
                        r_mac       <= bus.local_mac;
                        r_run       <= bus.run;
                        r_disc_ack  <= (w_pick == RT_DISC);
                        r_erase_ack <= (w_pick == RT_ERASE);
                        r_more_ack  <= (w_pick == RT_MORE);
                        r_sync      <= 1'b1;
                        r_req       <= 1'b1;
                        r_tmo       <= 32'h0;
                        r_state     <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    if (bus.udp_tx_enable) begin
                        r_idx   <= 16'h0;
                        r_data  <= w_mux_byte;
                        r_state <= ST_SEND;
                    end else if (r_tmo == 32'(REQ_TIMEOUT - 1)) begin
                        // Grant never came: abandon without consuming a counter value
                        r_req   <= 1'b0;
                        r_sync  <= 1'b0;
                        r_gap   <= 16'h0;
                        r_state <= ST_GAP;
                    end else begin
                        r_tmo <= r_tmo + 32'd1;
                    end
                end
                ST_SEND: begin
                    if (w_send_ok) begin
                        if (r_idx == 16'(PAYLOAD_LEN - 1)) begin
                            r_req   <= 1'b0;
                            r_sync  <= 1'b0;
                            r_cnt   <= r_cnt + 32'd1;
                            r_gap   <= 16'h0;
                            r_state <= ST_GAP;
                        end else begin
                            r_idx  <= r_idx + 16'd1;
                            r_data <= w_mux_byte;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap == 16'(GAP_CYCLES - 1))
                        r_state <= ST_IDLE;
                    else
                        r_gap <= r_gap + 16'd1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.udp_tx_length  = 16'(PAYLOAD_LEN);
    assign bus.udp_tx_active  = w_send_ok;
    assign bus.udp_tx_data    = w_send_ok ? r_data : 8'h00;
    assign bus.udp_tx_request = r_req;
    assign bus.sending_sync   = r_sync;
    assign bus.discovery_ACK  = r_disc_ack;
    assign bus.erase_ACK      = r_erase_ack;
    assign bus.send_more_ACK  = r_more_ack;
endmodule

// File: tb/tb_sdr_reply_send.sv
// Bench for sdr_reply_send: vector table of replies plus arbitration, timeout and reset sequences.
// Latency: expects first byte one clock after grant, one byte per granted clock.
// Backpressure: exercises an enable drop mid-packet.
module tb_sdr_reply_send;
    localparam int LEN = 60;
    localparam int TMO = 1024;
    localparam int GAP = 12;
    localparam logic [47:0] MAC0 = 48'h001C_C0A2_13DD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdr_reply_send_if bus();

    sdr_reply_send dut (
        .tx_clock (clk),
        .reset_n  (rst_n),
        .bus      (bus)
    );

    int          checks   = 0;
    int          errors   = 0;
    int          rx_total = 0;
    logic [7:0]  rx_log [0:2047];
    logic [7:0]  exp_q [$];
    logic [31:0] exp_cnt = 32'h0;

    typedef struct {
        int          kind;     // 1 discovery, 2 erase, 3 send_more
        logic        run;
        logic [47:0] mac;
        logic [31:0] seq;
        int          delay;    // clocks before grant
        int          drop_at;  // bytes received before an enable drop, -1 none
        logic [7:0]  exp_code;
    } vec_t;
    vec_t tbl [4];

    // Log every byte presented with udp_tx_active
    always @(negedge clk) begin
        if (rst_n && bus.udp_tx_active) begin
            if (rx_total < 2048) rx_log[rx_total] <= bus.udp_tx_data;
            rx_total <= rx_total + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, expv);
        end
    endtask

    task automatic set_req(input int kind, input logic v);
        case (kind)
            1: bus.discovery_reply = v;
            2: bus.erase_done      = v;
            default: bus.send_more = v;
        endcase
    endtask

    function automatic logic [2:0] ack_onehot(input int kind);
        case (kind)
            1: return 3'b100;
            2: return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    // Build the expected payload for the current reply counter
    task automatic push_exp(input int kind, input logic run, input logic [47:0] mac, input logic [31:0] seq);
        logic [7:0] b [LEN];
`ifdef SDR_REPLY_CHECKSUM_EN
        logic [15:0] s;
`endif
        for (int i = 0; i < LEN; i++) b[i] = 8'h00;
        b[0] = exp_cnt[31:24];
        b[1] = exp_cnt[23:16];
        b[2] = exp_cnt[15:8];
        b[3] = exp_cnt[7:0];
        if (kind == 1) begin
            b[4] = run ? 8'h03 : 8'h02;
            for (int k = 0; k < 6; k++) b[5+k] = mac[8*(5-k) +: 8];
            b[11] = 8'h06;
            b[12] = 8'd39;
            b[13] = 8'd10;
        end else if (kind == 2) begin
            b[4] = 8'h04;
        end else begin
            b[4] = 8'h05;
            for (int k = 0; k < 4; k++) b[5+k] = seq[8*(3-k) +: 8];
        end
`ifdef SDR_REPLY_CHECKSUM_EN
        s = 16'h0;
        for (int i = 0; i < LEN - 2; i++) s = s + {8'h00, b[i]};
        b[LEN-2] = s[15:8];
        b[LEN-1] = s[7:0];
`endif
        for (int i = 0; i < LEN; i++) exp_q.push_back(b[i]);
    endtask

    // Wait for the ACK, drop the served request, and check the ACK is a single pulse
    task automatic wait_ack(input int kind, input string nm, output int n);
        n = 0;
        while (!(bus.discovery_ACK | bus.erase_ACK | bus.send_more_ACK) && n < 200) begin
            tick;
            n++;
        end
        chk({nm, " ack"}, {bus.discovery_ACK, bus.erase_ACK, bus.send_more_ACK}, ack_onehot(kind));
        chk({nm, " sync at ack"}, bus.sending_sync, 1'b1);
        chk({nm, " request at ack"}, bus.udp_tx_request, 1'b1);
        set_req(kind, 1'b0);
        tick;
        chk({nm, " ack pulse"}, {bus.discovery_ACK, bus.erase_ACK, bus.send_more_ACK}, 3'b000);
    endtask

    // Grant the path, optionally drop enable mid-packet, and wait for sending_sync to fall
    task automatic wait_done(input int base, input int delay, input int drop_at, input string nm);
        int   cyc = 0;
        int   left = 0;
        bit   dropped = 0;
        logic last_act = 1'b0;
        if (delay == 0) bus.udp_tx_enable = 1'b1;
        while (cyc < 3000) begin
            tick;
            cyc++;
            if (!bus.sending_sync) break;
            last_act = bus.udp_tx_active;
            if (left > 0) begin
                chk({nm, " active during enable drop"}, bus.udp_tx_active, 1'b0);
                left--;
                if (left == 0) bus.udp_tx_enable = 1'b1;
            end else if (drop_at >= 0 && !dropped && (rx_total - base) >= drop_at) begin
                bus.udp_tx_enable = 1'b0;
                dropped = 1;
                left = 3;
            end
            if (cyc == delay) bus.udp_tx_enable = 1'b1;
        end
        chk({nm, " sync fell"}, bus.sending_sync, 1'b0);
        chk({nm, " sync falls with last byte"}, last_act, 1'b1);
        chk({nm, " active after end"}, bus.udp_tx_active, 1'b0);
        chk({nm, " request after end"}, bus.udp_tx_request, 1'b0);
        chk({nm, " byte count"}, 64'(rx_total - base), 64'(LEN));
        bus.udp_tx_enable = 1'b0;
    endtask

    // Pop one packet of expected bytes and compare with what was logged
    task automatic compare_pkt(input int base, input string nm);
        logic [7:0] e;
        for (int i = 0; i < LEN; i++) begin
            if (exp_q.size() == 0) begin
                chk($sformatf("%s scoreboard empty at byte%0d", nm, i), 64'd1, 64'd0);
                break;
            end
            e = exp_q.pop_front();
            chk($sformatf("%s byte%0d", nm, i), rx_log[base+i], e);
        end
    endtask

    // Independent sum for a discovery reply with run=0 at the given counter
    function automatic logic [15:0] disc_sum(input logic [31:0] cnt, input logic [47:0] mac);
        logic [15:0] s;
        s = 16'h0002 + 16'h0006 + 16'h0027 + 16'h000A;
        for (int k = 0; k < 4; k++) s = s + {8'h00, cnt[8*k +: 8]};
        for (int k = 0; k < 6; k++) s = s + {8'h00, mac[8*k +: 8]};
        return s;
    endfunction

    initial begin
        int          base;
        int          n;
        logic [15:0] cs;

        tbl[0] = '{kind: 1, run: 1'b0, mac: MAC0,               seq: 32'h0,         delay: 3, drop_at: -1, exp_code: 8'h02};
        tbl[1] = '{kind: 3, run: 1'b0, mac: 48'h0,              seq: 32'hDEADBEEF,  delay: 1, drop_at: 20, exp_code: 8'h05};
        tbl[2] = '{kind: 1, run: 1'b1, mac: 48'h0A0B_0C0D_0E0F, seq: 32'h12345678,  delay: 5, drop_at: -1, exp_code: 8'h03};
        tbl[3] = '{kind: 2, run: 1'b1, mac: 48'hFFFF_FFFF_FFFF, seq: 32'hFFFFFFFF,  delay: 0, drop_at: -1, exp_code: 8'h04};

        bus.discovery_reply = 1'b0;
        bus.erase_done      = 1'b0;
        bus.send_more       = 1'b0;
        bus.run             = 1'b0;
        bus.local_mac       = 48'h0;
        bus.sequence_number = 32'h0;
        bus.udp_tx_enable   = 1'b0;

        repeat (3) tick;
        chk("reset active",  bus.udp_tx_active, 1'b0);
        chk("reset data",    bus.udp_tx_data, 8'h00);
        chk("reset request", bus.udp_tx_request, 1'b0);
        chk("reset sync",    bus.sending_sync, 1'b0);
        chk("reset acks",    {bus.discovery_ACK, bus.erase_ACK, bus.send_more_ACK}, 3'b000);
        chk("reset length",  bus.udp_tx_length, 16'd60);
        rst_n = 1'b1;
        repeat (2) tick;

        // Vector table: one reply per entry
        for (int v = 0; v < 4; v++) begin
            base = rx_total;
            bus.run             = tbl[v].run;
            bus.local_mac       = tbl[v].mac;
            bus.sequence_number = tbl[v].seq;
            push_exp(tbl[v].kind, tbl[v].run, tbl[v].mac, tbl[v].seq);
            set_req(tbl[v].kind, 1'b1);
            wait_ack(tbl[v].kind, $sformatf("vec%0d", v), n);
            wait_done(base, tbl[v].delay, tbl[v].drop_at, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d code", v), rx_log[base+4], tbl[v].exp_code);
            if (v == 0) begin
`ifdef SDR_REPLY_CHECKSUM_EN
                cs = disc_sum(exp_cnt, MAC0);
`else
                cs = 16'h0000;
`endif
                chk("checksum hi", rx_log[base+LEN-2], cs[15:8]);
                chk("checksum lo", rx_log[base+LEN-1], cs[7:0]);
            end
            compare_pkt(base, $sformatf("vec%0d", v));
            exp_cnt = exp_cnt + 32'd1;
        end

        // Grant never arrives: reply abandoned after the timeout, counter unchanged
        base = rx_total;
        set_req(1, 1'b1);
        wait_ack(1, "timeout", n);
        n = 2;
        while (n < 1200) begin
            tick;
            if (!bus.sending_sync) break;
            n++;
        end
        chk("timeout sync duration", 64'(n), 64'(TMO));
        chk("timeout no bytes", 64'(rx_total - base), 64'd0);
        chk("timeout request", bus.udp_tx_request, 1'b0);

        // Simultaneous erase and discovery: erase first, discovery after the gap
        base = rx_total;
        bus.run       = 1'b0;
        bus.local_mac = MAC0;
        push_exp(2, 1'b0, MAC0, 32'h0);
        bus.erase_done      = 1'b1;
        bus.discovery_reply = 1'b1;
        wait_ack(2, "arb erase", n);
        wait_done(base, 0, -1, "arb erase");
        compare_pkt(base, "arb erase");
        exp_cnt = exp_cnt + 32'd1;
        base = rx_total;
        push_exp(1, 1'b0, MAC0, 32'h0);
        wait_ack(1, "arb disc", n);
        chk("arb gap respected", (n >= GAP), 1'b1);
        wait_done(base, 0, -1, "arb disc");
        compare_pkt(base, "arb disc");
        exp_cnt = exp_cnt + 32'd1;

        // Reset in the middle of a packet
        base = rx_total;
        set_req(1, 1'b1);
        wait_ack(1, "rst", n);
        bus.udp_tx_enable = 1'b1;
        n = 0;
        while ((rx_total - base) < 30 && n < 200) begin
            tick;
            n++;
        end
        chk("rst bytes before reset", 64'(rx_total - base), 64'd30);
        #2 rst_n = 1'b0;
        #1;
        chk("rst active",  bus.udp_tx_active, 1'b0);
        chk("rst data",    bus.udp_tx_data, 8'h00);
        chk("rst request", bus.udp_tx_request, 1'b0);
        chk("rst sync",    bus.sending_sync, 1'b0);
        chk("rst acks",    {bus.discovery_ACK, bus.erase_ACK, bus.send_more_ACK}, 3'b000);
        chk("rst length",  bus.udp_tx_length, 16'd60);
        bus.udp_tx_enable = 1'b0;
        repeat (3) tick;
        rst_n = 1'b1;
        exp_cnt = 32'h0;
        tick;

        // After reset the next discovery starts over at byte 0 with counter 0
        base = rx_total;
        push_exp(1, 1'b0, MAC0, 32'h0);
        set_req(1, 1'b1);
        wait_ack(1, "post rst", n);
        wait_done(base, 2, -1, "post rst");
        compare_pkt(base, "post rst");

        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdr_reply_send.md
Name: sdr_reply_send

Overview:
- Transmit-side counterpart of the port-1024 command receiver. It builds the fixed 60-byte UDP reply payloads to the PC: discovery reply, erase-complete, and program "send more".
- It arbitrates the pending reply requests, acknowledges each request, and requests the UDP/IP transmit path.
- It streams one payload byte per clock, and drives sending_sync so the receiver's command state machine knows when the reply has finished.

Parameters:
- BOARD_ID, 8'h06, board type reported in discovery byte 11.
- PROTOCOL_VERSION, 8'd39, byte 12.
- CODE_VERSION, 8'd10, byte 13.
- PAYLOAD_LEN, 60, payload bytes per reply. Minimum 20.
- REQ_TIMEOUT, 1024, clocks to wait for udp_tx_enable before the reply is abandoned.
- GAP_CYCLES, 12, minimum idle clocks between replies.

Ports:
- tx_clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- discovery_reply  in  1  level request, held until discovery_ACK
- erase_done  in  1  level request, held until erase_ACK
- send_more  in  1  level request, held until send_more_ACK
- run  in  1  radio streaming; selects the discovery status code
- local_mac  in  48  MAC address reported in discovery replies
- sequence_number  in  32  PC sequence number, echoed in send_more replies
- udp_tx_enable  in  1  transmit path grant; one byte is consumed per clock while sending
- discovery_ACK  out  1  one-cycle pulse
- erase_ACK  out  1  one-cycle pulse
- send_more_ACK  out  1  one-cycle pulse
- udp_tx_request  out  1  request to the UDP transmit path
- udp_tx_length  out  16  always PAYLOAD_LEN
- udp_tx_data  out  8  payload byte
- udp_tx_active  out  1  udp_tx_data is valid this clock
- sending_sync  out  1  high from request until the last byte is sent

Behaviour:
- Reset: all outputs 0 except udp_tx_length = PAYLOAD_LEN. Reply sequence counter = 0. State = IDLE.

States: IDLE -> REQUEST -> SEND -> GAP -> IDLE.

IDLE:
- Serve the highest-priority pending request: erase_done > send_more > discovery_reply.
- Latch the reply type and sequence_number.
- Pulse the matching *_ACK for exactly one clock.
- Set sending_sync and udp_tx_request. Go to REQUEST.
- Requests not served stay pending. They are not lost.

REQUEST:
- Wait for udp_tx_enable. On the enable edge, go to SEND with byte index 0.
- The first byte appears on the clock after the enable edge (latency 1).
- If REQ_TIMEOUT clocks pass without enable: drop the request and clear sending_sync. Go to GAP. The sequence counter is not incremented.

SEND:
- udp_tx_active = 1. Output one byte per clock for index 0..PAYLOAD_LEN-1.
- After the last byte: clear udp_tx_active, udp_tx_request and sending_sync in the same clock. Increment the reply counter (32-bit, wraps FFFFFFFF->0). Go to GAP.
- If udp_tx_enable drops mid-packet: hold the current byte and index, and keep udp_tx_active low until enable returns.

GAP:
- Count GAP_CYCLES clocks, then go to IDLE.

Payload layout:
- Bytes 0-3: reply counter, MSB first.
- Byte 4: reply code.
  - Discovery: 0x02 if !run, 0x03 if run.
  - Erase done: 0x04.
  - Send more: 0x05.
- Discovery replies:
  - Bytes 5-10: local_mac, MSB first.
  - Byte 11: BOARD_ID. Byte 12: PROTOCOL_VERSION. Byte 13: CODE_VERSION.
- Send-more replies: bytes 5-8 = latched sequence_number, MSB first.
- All other bytes are 0x00.

Input sampling and timing:
- local_mac and run are sampled when the request is latched in IDLE.
- A request that is still asserted after its ACK is served again once GAP ends. Requesters must drop the request on the ACK.

Optional Feature:
- Macro: SDR_REPLY_CHECKSUM_EN.
- Defined: bytes PAYLOAD_LEN-2 and PAYLOAD_LEN-1 carry a 16-bit modulo-2^16 sum of bytes 0..PAYLOAD_LEN-3, MSB first. The sum accumulates during SEND, one clock behind the output mux.
- Undefined: those two bytes are 0x00 and no accumulator is synthesized.

Decomposition:
- Shared package sdr_proto_pkg:
  - Reply codes: REPLY_IDLE = 2, REPLY_RUN = 3, REPLY_ERASE = 4, REPLY_MORE = 5.
  - Typedef for the reply type (none/discovery/erase/more).
  - UDP port constant 1024.
- One natural sub-module, sdr_reply_mux: combinational byte-index-to-byte mux taking the latched fields. The FSM, counters and checksum stay in the top.

Test Plan:
- Discovery, run=0, local_mac=0x00_1C_C0_A2_13_DD, enable granted 3 clocks after request:
  - discovery_ACK pulses once; 60 bytes sent.
  - Bytes 0-3 = 0, byte 4 = 0x02, bytes 5-10 = MAC, bytes 11-13 = 06/27/0A, remainder 0.
  - sending_sync falls with the last byte.
- erase_done and discovery_reply asserted in the same clock:
  - Erase reply (code 0x04, counter 0) is sent first.
  - Discovery follows after GAP_CYCLES with counter 1.
- send_more with sequence_number = 0xDEADBEEF -> byte 4 = 0x05, bytes 5-8 = DE AD BE EF.
- udp_tx_enable never asserted:
  - After 1024 clocks sending_sync drops with no bytes sent.
  - The next reply still uses counter 0.
- reset_n asserted at byte 30:
  - All outputs go to 0 immediately.
  - After release, a new discovery restarts at byte 0 with counter 0.
- SDR_REPLY_CHECKSUM_EN defined, discovery with the MAC above:
  - Bytes 58-59 equal the 16-bit sum of bytes 0-57.
  - Without the macro, bytes 58-59 are 0x00.
